// File: rtl/rom_lookup_arbiter.sv
// Round-robin arbiter sharing one combinational sensor-code ROM among NUM_REQ requesters.
// One lookup per three cycles: grant in IDLE, address the ROM in LOOKUP, acknowledge in DONE.
module rom_lookup_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*AW-1:0] addr_i,
  output logic [NUM_REQ-1:0]    ack_o,
  output logic [DW-1:0]         rsp_data_o,
  output logic                  rsp_invalid_o,
  output logic [AW-1:0]         rom_addr_o,
  input  logic [DW-1:0]         rom_data_i,
  output logic                  busy_o
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StLookup, StDone} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 invalid_q, invalid_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [DW-1:0]        rsp_data_q, rsp_data_d;
  logic                 rsp_invalid_q, rsp_invalid_d;

  logic                 win_found;
  logic [IW-1:0]        win_idx;
  logic [AW-1:0]        win_addr;
  logic                 win_onehot;
  int unsigned          cand;

  // First requesting index at or after rr_ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_addr  = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!win_found && req_i[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
        win_addr  = addr_i[cand*AW +: AW];
      end
    end
    win_onehot = (win_addr != '0) && ((win_addr & (win_addr - 1'b1)) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      addr_q        <= '0;
      invalid_q     <= 1'b0;
      ack_q         <= '0;
      rsp_data_q    <= '0;
      rsp_invalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      addr_q        <= addr_d;
      invalid_q     <= invalid_d;
      ack_q         <= ack_d;
      rsp_data_q    <= rsp_data_d;
      rsp_invalid_q <= rsp_invalid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    addr_d        = addr_q;
    invalid_d     = invalid_q;
    ack_d         = '0;
    rsp_data_d    = rsp_data_q;
    rsp_invalid_d = rsp_invalid_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d   = win_idx;
          addr_d    = win_addr;
          invalid_d = !win_onehot;
          state_d   = StLookup;
        end
      end
      StLookup: begin
        rsp_data_d     = rom_data_i;
        rsp_invalid_d  = invalid_q;
        ack_d[grant_q] = 1'b1;
        rr_ptr_d       = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d        = StDone;
      end
      StDone: begin
        // Requests are ignored here so the just-served requester cannot retrigger early.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    rom_addr_o    = (state_q == StLookup) ? addr_q : '0;
    busy_o        = (state_q != StIdle);
    ack_o         = ack_q;
    rsp_data_o    = rsp_data_q;
    rsp_invalid_o = rsp_invalid_q;
  end

endmodule

// File: tb/tb_rom_lookup_arbiter.sv
// Directed bench for rom_lookup_arbiter: expected acks are queued when requests are
// driven and popped as the DUT acknowledges them.
module tb_rom_lookup_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned AW      = 5;
  localparam int unsigned DW      = 5;

  typedef struct {
    int           idx;
    logic [DW-1:0] data;
    logic         inv;
  } exp_t;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] addr;
  logic [NUM_REQ-1:0]    ack;
  logic [DW-1:0]         rsp_data;
  logic                  rsp_inv;
  logic [AW-1:0]         rom_addr;
  logic [DW-1:0]         rom_data;
  logic                  busy;

  exp_t               exp_q[$];
  int                 total;
  int                 bad;
  int                 cyc;
  int                 last_cyc;
  bit                 have_last;
  bit                 gap_en;
  logic [NUM_REQ-1:0] hold;

  function automatic logic [DW-1:0] rom_model(input logic [AW-1:0] a);
    case (a)
      5'd1:    return 5'd1;
      5'd2:    return 5'd0;
      5'd4:    return 5'd2;
      5'd8:    return 5'd3;
      5'd16:   return 5'd17;
      default: return 5'd0;
    endcase
  endfunction

  assign rom_data = rom_model(rom_addr);

  rom_lookup_arbiter #(
    .NUM_REQ (NUM_REQ),
    .AW      (AW),
    .DW      (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req),
    .addr_i        (addr),
    .ack_o         (ack),
    .rsp_data_o    (rsp_data),
    .rsp_invalid_o (rsp_inv),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input logic [DW-1:0] data, input logic inv);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    e.inv  = inv;
    exp_q.push_back(e);
  endtask

  task automatic set_addr(input int k, input logic [AW-1:0] a);
    addr[k*AW +: AW] = a;
  endtask

  // Advance to the next falling edge and score any acknowledge seen there.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (ack !== '0) begin
      chk("ack_onehot", $countones(ack), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_idx", 32'(ack), 32'(1) << e.idx);
        chk("ack_data", 32'(rsp_data), 32'(e.data));
        chk("ack_invalid", 32'(rsp_inv), 32'(e.inv));
        if (gap_en && have_last) chk("ack_gap", cyc - last_cyc, 3);
        last_cyc  = cyc;
        have_last = 1'b1;
      end
      req = req & ~(ack & ~hold);
    end
  endtask

  task automatic wait_acks(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("ack_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    cyc       = 0;
    last_cyc  = 0;
    have_last = 1'b0;
    gap_en    = 1'b0;
    hold      = '0;
    rst       = 1'b1;
    req       = '0;
    addr      = '0;

    // Reset state
    repeat (3) step();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_data", 32'(rsp_data), 0);
    chk("rst_inv", 32'(rsp_inv), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    step();

    // Single request, latency and busy window
    set_addr(2, 5'b01000);
    req = 4'b0100;
    push(2, 5'd3, 1'b0);
    step();
    chk("single_rom_addr", 32'(rom_addr), 8);
    chk("single_busy1", 32'(busy), 1);
    chk("single_noack", 32'(ack), 0);
    step();
    chk("single_busy2", 32'(busy), 1);
    chk("single_acked", exp_q.size(), 0);
    step();
    chk("single_busy_end", 32'(busy), 0);
    chk("single_ack_clr", 32'(ack), 0);
    chk("single_rom_idle", 32'(rom_addr), 0);
    chk("single_data_hold", 32'(rsp_data), 3);

    // All four from reset: order 0..3, three cycles apart
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_addr(0, 5'd1);
    set_addr(1, 5'd2);
    set_addr(2, 5'd4);
    set_addr(3, 5'd16);
    req       = 4'b1111;
    gap_en    = 1'b1;
    have_last = 1'b0;
    push(0, 5'd1, 1'b0);
    push(1, 5'd0, 1'b0);
    push(2, 5'd2, 1'b0);
    push(3, 5'd17, 1'b0);
    wait_acks(40);
    gap_en = 1'b0;

    // Invalid addresses: multi-hot and zero
    set_addr(1, 5'b00011);
    req = 4'b0010;
    push(1, 5'd0, 1'b1);
    wait_acks(20);
    set_addr(3, 5'b00000);
    req = 4'b1000;
    push(3, 5'd0, 1'b1);
    wait_acks(20);

    // Fairness: both held continuously, grants alternate
    set_addr(0, 5'd1);
    set_addr(1, 5'd16);
    hold      = 4'b0011;
    req       = 4'b0011;
    gap_en    = 1'b1;
    have_last = 1'b0;
    push(0, 5'd1, 1'b0);
    push(1, 5'd17, 1'b0);
    push(0, 5'd1, 1'b0);
    push(1, 5'd17, 1'b0);
    wait_acks(40);
    req    = '0;
    hold   = '0;
    gap_en = 1'b0;

    // Reset mid-LOOKUP: pointer is at 2 so requester 3 is in flight
    set_addr(1, 5'd4);
    set_addr(3, 5'd8);
    step();
    req = 4'b1010;
    step();
    chk("midrst_rom_addr", 32'(rom_addr), 8);
    rst = 1'b1;
    step();
    chk("midrst_ack", 32'(ack), 0);
    chk("midrst_rom_addr0", 32'(rom_addr), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_data", 32'(rsp_data), 0);
    chk("midrst_inv", 32'(rsp_inv), 0);
    rst = 1'b0;
    push(1, 5'd2, 1'b0);
    push(3, 5'd3, 1'b0);
    wait_acks(40);

    // Request dropped during LOOKUP still gets its ack, and nothing more
    set_addr(1, 5'd1);
    step();
    req = 4'b0010;
    push(1, 5'd1, 1'b0);
    step();
    chk("drop_rom_addr", 32'(rom_addr), 1);
    req = '0;
    wait_acks(20);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("drop_no_regrant", 32'(busy), 0);
    end
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_lookup_arbiter.md
# rom_lookup_arbiter

Round-robin arbiter that shares the cruise-control 5-bit sensor-code lookup ROM among up to NUM_REQ requesters (speed, brake, throttle, set/resume logic). Each requester presents a one-hot sensor address with a level request. The arbiter grants one requester at a time, drives the ROM address, registers the returned code, and pulses an acknowledge with the data. The ROM itself is purely combinational and sits outside this block.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- AW, 5: ROM address width.
- DW, 5: ROM data width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester lookup request, level; held until own ack.
- addr_i  input  NUM_REQ*AW  per-requester address; slice k = addr_i[k*AW +: AW]; stable while req_i[k] high.
- ack_o  output  NUM_REQ  one-cycle acknowledge, at most one bit set.
- rsp_data_o  output  DW  looked-up code; valid while any ack_o bit high.
- rsp_invalid_o  output  1  high with ack when the granted address was not exactly one-hot.
- rom_addr_o  output  AW  address to ROM; 0 outside LOOKUP.
- rom_data_i  input  DW  combinational ROM output.
- busy_o  output  1  high in LOOKUP and DONE.

## Operation
- FSM states: IDLE, LOOKUP, DONE.
- IDLE: if any req_i bit set, pick a winner by round-robin starting at pointer rr_ptr, wrapping modulo NUM_REQ. Register grant index and addr slice into addr_q, set invalid_q = (addr not one-hot), go to LOOKUP. If no request, stay in IDLE.
- LOOKUP: rom_addr_o = addr_q. At the clock edge, capture rom_data_i into rsp_data_o and invalid_q into rsp_invalid_o. Set ack_o[grant]=1, set rr_ptr = (grant+1) mod NUM_REQ, go to DONE.
- DONE: ack_o held for exactly this cycle. req_i is ignored. Next edge: ack_o cleared, go to IDLE.
- rsp_data_o and rsp_invalid_o hold their last values until the next capture.
- Address 0 and multi-hot addresses are still looked up: the ROM returns its default code, and the rsp_invalid_o flag is set.
- A requester that keeps req_i high after its ack is treated as a new request. Round-robin order gives every other pending requester priority first.
- A requester dropping req_i during LOOKUP does not abort the lookup; the ack is still issued.

## Timing
- Reset values: state IDLE, rr_ptr 0, ack_o 0, rsp_data_o 0, rsp_invalid_o 0, rom_addr_o 0, busy_o 0.
- Latency: req sampled at edge E0 → rom_addr_o valid in cycle E0..E1 → ack_o high in cycle E1..E2.
- Throughput: one lookup per 3 cycles under continuous demand.
- Worst-case wait from req to grant: 3*(NUM_REQ-1) cycles.
- Reset asserted in any state: all registers return to reset values on that edge. An in-flight lookup is dropped with no ack. rr_ptr returns to 0.
- Simultaneous requests at reset exit: requester 0 wins first.
- rom_addr_o and busy_o are decoded from registered state only (glitch-free from rst/req).

## Test plan
ROM mapping used by the bench model: 1→1, 2→0, 4→2, 8→3, 16→17, all other addresses→0.

- Single request: req_i[2]=1, addr 5'b01000 → rom_addr_o=8 one cycle later, then ack_o=4'b0100, rsp_data_o=3, rsp_invalid_o=0, 2 cycles after sampling; busy_o high for exactly 2 cycles.
- All four requesting from reset with addrs 1,2,4,16 → acks in order 0,1,2,3 with data 1,0,2,17, spaced 3 cycles apart; never two ack bits at once.
- Invalid addresses: addr 5'b00011 → rsp_data_o=0, rsp_invalid_o=1. Addr 0 → rsp_data_o=0, rsp_invalid_o=1.
- Fairness: req 0 held high continuously while req 1 is raised → grant order 0,1,0,1; requester 1 is never starved.
- Reset mid-LOOKUP: rst pulsed in LOOKUP → no ack; all outputs 0 the next cycle. The pending request is re-granted starting from requester 0.
- Drop during LOOKUP: req_i[1] deasserted in LOOKUP cycle → ack_o[1] still pulses with correct data; no further grant to requester 1.
